xrek_verify_scheduler: RTL and testbench

//  Shares the single XREK verification engine among N_REQ execution lanes and sequences each lane's verification loop.
//  - Arbitration: round-robin between the lanes.
//  - Issue: one-cycle engine start pulse per attempt.
//  - Loop control: waits for the result, retries after a programmable backoff, declares rollback or timeout.
//  - Completion: returns a per-lane response.

---
 rtl/xrek_verify_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_xrek_verify_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xrek_verify_scheduler.sv
// Round-robin scheduler sharing one XREK verification engine among N_REQ lanes:
// issues attempts, retries after a backoff, and reports pass / rollback / timeout.
module xrek_verify_scheduler #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ID_W      = 32,
  parameter int unsigned BACKOFF_W = 8,
  parameter int unsigned TMO_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 cfg_max_retries,
  input  logic [BACKOFF_W-1:0]       cfg_backoff,
  input  logic [TMO_W-1:0]           cfg_timeout,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*ID_W-1:0]      req_step_id,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       eng_start,
  output logic [ID_W-1:0]            eng_step_id,
  output logic [7:0]                 eng_retry_idx,
  input  logic                       eng_done,
  input  logic                       eng_pass,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [1:0]                 rsp_status,
  output logic [7:0]                 rsp_retries,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_idx
);

  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned RW = 8;

  localparam logic [1:0] ST_PASS     = 2'd1;
  localparam logic [1:0] ST_ROLLBACK = 2'd2;
  localparam logic [1:0] ST_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_BACKOFF,
    S_RESPOND
  } state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        ptr_q, ptr_d;
  logic [GW-1:0]        gidx_q, gidx_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [RW-1:0]        max_q, max_d;
  logic [BACKOFF_W-1:0] bo_cfg_q, bo_cfg_d;
  logic [TMO_W-1:0]     tmo_cfg_q, tmo_cfg_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [BACKOFF_W-1:0] bo_q, bo_d;
  logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [1:0]           rsp_status_q, rsp_status_d;
  logic [RW-1:0]        rsp_retries_q, rsp_retries_d;
  logic                 eng_start_q;
  logic                 busy_q;

  logic                 gnt_found;
  logic [GW-1:0]        gnt_lane;
  int unsigned          arb_idx;
  logic                 tmo_expire;
  logic                 enter_rsp;
  logic [1:0]           rsp_code;
  logic [N_REQ-1:0]     gidx_onehot;

  // First requesting lane after the RR pointer, with wrap
  always_comb begin
    gnt_found = 1'b0;
    gnt_lane  = '0;
    arb_idx   = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      arb_idx = (32'(ptr_q) + k) % N_REQ;
      if (!gnt_found && req_valid[arb_idx]) begin
        gnt_found = 1'b1;
        gnt_lane  = GW'(arb_idx);
      end
    end
  end

  assign req_ready   = (state_q == S_IDLE && gnt_found) ? (N_REQ'(1) << gnt_lane) : '0;
  assign gidx_onehot = N_REQ'(1) << gidx_q;
  // Expiry is the WAIT cycle in which the counter would reach zero
  assign tmo_expire  = (tmo_cfg_q != '0) && (tmo_q == TMO_W'(1));

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gidx_d        = gidx_q;
    id_d          = id_q;
    max_d         = max_q;
    bo_cfg_d      = bo_cfg_q;
    tmo_cfg_d     = tmo_cfg_q;
    retry_d       = retry_q;
    tmo_d         = tmo_q;
    bo_d          = bo_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_status_d  = rsp_status_q;
    rsp_retries_d = rsp_retries_q;
    enter_rsp     = 1'b0;
    rsp_code      = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          gidx_d    = gnt_lane;
          ptr_d     = gnt_lane;
          id_d      = req_step_id[32'(gnt_lane)*ID_W +: ID_W];
          max_d     = cfg_max_retries;
          bo_cfg_d  = cfg_backoff;
          tmo_cfg_d = cfg_timeout;
          retry_d   = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = tmo_cfg_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result in the expiry cycle takes precedence over the timeout
        if (eng_done) begin
          if (eng_pass) begin
            enter_rsp = 1'b1;
            rsp_code  = ST_PASS;
          end else if (retry_q < max_q) begin
            retry_d = retry_q + RW'(1);
            bo_d    = bo_cfg_q;
            state_d = S_BACKOFF;
          end else begin
            enter_rsp = 1'b1;
            rsp_code  = ST_ROLLBACK;
          end
        end else if (tmo_expire) begin
          enter_rsp = 1'b1;
          rsp_code  = ST_TIMEOUT;
        end else if (tmo_q != '0) begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      S_BACKOFF: begin
        if (bo_q == '0) state_d = S_ISSUE;
        else            bo_d    = bo_q - BACKOFF_W'(1);
      end
      S_RESPOND: begin
        if (rsp_ready[gidx_q]) begin
          rsp_valid_d   = '0;
          rsp_status_d  = 2'd0;
          rsp_retries_d = '0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_rsp) begin
      rsp_valid_d   = gidx_onehot;
      rsp_status_d  = rsp_code;
      rsp_retries_d = retry_q;
      state_d       = S_RESPOND;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= GW'(N_REQ - 1);
      gidx_q        <= '0;
      id_q          <= '0;
      max_q         <= '0;
      bo_cfg_q      <= '0;
      tmo_cfg_q     <= '0;
      retry_q       <= '0;
      tmo_q         <= '0;
      bo_q          <= '0;
      rsp_valid_q   <= '0;
      rsp_status_q  <= 2'd0;
      rsp_retries_q <= '0;
      eng_start_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gidx_q        <= gidx_d;
      id_q          <= id_d;
      max_q         <= max_d;
      bo_cfg_q      <= bo_cfg_d;
      tmo_cfg_q     <= tmo_cfg_d;
      retry_q       <= retry_d;
      tmo_q         <= tmo_d;
      bo_q          <= bo_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_status_q  <= rsp_status_d;
      rsp_retries_q <= rsp_retries_d;
      eng_start_q   <= (state_d == S_ISSUE);
      busy_q        <= (state_d != S_IDLE);
    end
  end

  assign eng_start     = eng_start_q;
  assign eng_step_id   = id_q;
  assign eng_retry_idx = retry_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_status    = rsp_status_q;
  assign rsp_retries   = rsp_retries_q;
  assign busy          = busy_q;
  assign grant_idx     = gidx_q;

endmodule

// File: tb/tb_xrek_verify_scheduler.sv
// Bench for xrek_verify_scheduler: per-job timeline model derived from the
// scheduling rules, checked against the DUT every cycle, plus literal pins.
module tb_xrek_verify_scheduler;
  localparam int N   = 4;
  localparam int IDW = 32;
  localparam int BOW = 8;
  localparam int TW  = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       cfg_max_retries;
  logic [BOW-1:0]   cfg_backoff;
  logic [TW-1:0]    cfg_timeout;
  logic [N-1:0]     req_valid;
  logic [N*IDW-1:0] req_step_id;
  logic [N-1:0]     req_ready;
  logic             eng_start;
  logic [IDW-1:0]   eng_step_id;
  logic [7:0]       eng_retry_idx;
  logic             eng_done;
  logic             eng_pass;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready;
  logic [1:0]       rsp_status;
  logic [7:0]       rsp_retries;
  logic             busy;
  logic [1:0]       grant_idx;

  xrek_verify_scheduler #(.N_REQ(N), .ID_W(IDW), .BACKOFF_W(BOW), .TMO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_max_retries(cfg_max_retries), .cfg_backoff(cfg_backoff), .cfg_timeout(cfg_timeout),
    .req_valid(req_valid), .req_step_id(req_step_id), .req_ready(req_ready),
    .eng_start(eng_start), .eng_step_id(eng_step_id), .eng_retry_idx(eng_retry_idx),
    .eng_done(eng_done), .eng_pass(eng_pass),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_retries(rsp_retries), .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Expected outputs for the current cycle
  logic [N-1:0]   exp_req_ready, exp_rsp_valid;
  logic           exp_eng_start, exp_busy;
  logic [IDW-1:0] exp_id;
  logic [7:0]     exp_ridx, exp_rsp_retries;
  logic [1:0]     exp_status, exp_gidx;

  int model_ptr;
  int scr_kind[8];   // 0 pass, 1 fail, 2 never answers
  int scr_delay[8];  // cycles from eng_start to eng_done

  int obs_starts[$];
  bit obs_rsp_seen;
  int obs_rsp_cyc, obs_status, obs_retries, obs_lane;
  int m_t0;
  int lanes_seen[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready",     64'(req_ready),     64'(exp_req_ready));
      chk("eng_start",     64'(eng_start),     64'(exp_eng_start));
      chk("busy",          64'(busy),          64'(exp_busy));
      chk("grant_idx",     64'(grant_idx),     64'(exp_gidx));
      chk("eng_step_id",   64'(eng_step_id),   64'(exp_id));
      chk("eng_retry_idx", 64'(eng_retry_idx), 64'(exp_ridx));
      chk("rsp_valid",     64'(rsp_valid),     64'(exp_rsp_valid));
      chk("rsp_status",    64'(rsp_status),    64'(exp_status));
      chk("rsp_retries",   64'(rsp_retries),   64'(exp_rsp_retries));
    end
  end

  always @(negedge clk) begin
    if (eng_start === 1'b1) obs_starts.push_back(cyc);
    if (rsp_valid != '0 && !obs_rsp_seen) begin
      obs_rsp_seen = 1'b1;
      obs_rsp_cyc  = cyc;
      obs_status   = int'(rsp_status);
      obs_retries  = int'(rsp_retries);
      obs_lane     = int'(grant_idx);
    end
  end

  function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int count_lt(input int q[$], input int v);
    int n = 0;
    foreach (q[i]) if (q[i] < v) n++;
    return n;
  endfunction

  task automatic set_script(input int kind, input int d);
    for (int i = 0; i < 8; i++) begin
      scr_kind[i]  = kind;
      scr_delay[i] = d;
    end
  endtask

  task automatic clear_exp();
    exp_req_ready = '0; exp_rsp_valid = '0; exp_eng_start = 1'b0; exp_busy = 1'b0;
    exp_id = '0; exp_ridx = '0; exp_rsp_retries = '0; exp_status = 2'd0; exp_gidx = 2'd0;
  endtask

  // Idle cycles with stray engine strobes and response readies that must be ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = '0; eng_done = 1'b1; eng_pass = 1'b1; rsp_ready = '1;
      cfg_max_retries = 8'(i); cfg_backoff = 8'(i + 3); cfg_timeout = 16'(i + 1);
      exp_req_ready = '0; exp_eng_start = 1'b0; exp_busy = 1'b0;
      exp_rsp_valid = '0; exp_status = 2'd0; exp_rsp_retries = '0;
      @(posedge clk); #1;
    end
  endtask

  // One job from grant to accept; abort>0 pulls reset at that relative cycle
  task automatic do_job(input logic [N-1:0] reqs, input logic [31:0] id, input int mx,
                        input int bo, input int tmo, input int hold, input int abort);
    int lane, s, k, st, dec, r_c, a_c, last;
    int starts[$];
    int dones[$];
    int fails[$];
    int passes[$];
    logic [N-1:0] oh;
    lane = rr_pick(model_ptr, reqs);
    model_ptr = lane;
    oh = N'(1) << lane;
    s = 1; k = 0; st = 0; dec = 0;
    for (int a = 0; a < 8; a++) begin
      starts.push_back(s);
      if (scr_kind[a] == 2 || (tmo != 0 && scr_delay[a] > tmo)) begin
        st = 3; dec = s + tmo; break;
      end
      dones.push_back(s + scr_delay[a]);
      if (scr_kind[a] == 0) begin
        st = 1; dec = s + scr_delay[a]; passes.push_back(dec); break;
      end
      if (k < mx) begin
        k++; fails.push_back(s + scr_delay[a]); s = s + scr_delay[a] + bo + 2;
      end else begin
        st = 2; dec = s + scr_delay[a]; break;
      end
    end
    r_c = dec + 1;
    a_c = r_c + hold;
    last = (abort > 0) ? abort : a_c;
    m_t0 = cyc;
    obs_starts.delete();
    obs_rsp_seen = 1'b0;
    for (int c = 0; c <= last; c++) begin
      if (abort > 0 && c == abort) begin
        rst_n = 1'b0; req_valid = '0; eng_done = 1'b0; eng_pass = 1'b0; rsp_ready = '0;
        model_ptr = N - 1;
        clear_exp();
        @(posedge clk); #1;
        return;
      end
      req_valid = reqs;
      for (int i = 0; i < N; i++)
        req_step_id[i*IDW +: IDW] = (c == 0 && i == lane) ? id : (~id ^ 32'(i * 7 + c));
      cfg_max_retries = (c == 0) ? 8'(mx)  : 8'(mx) ^ 8'h01;
      cfg_backoff     = (c == 0) ? 8'(bo)  : 8'(bo) ^ 8'h05;
      cfg_timeout     = (c == 0) ? 16'(tmo) : 16'(tmo) ^ 16'h0003;
      eng_done = in_q(dones, c) || in_q(starts, c) || in_q(fails, c - 1) || (c == r_c);
      eng_pass = in_q(dones, c) ? in_q(passes, c) : 1'b1;
      rsp_ready = (c == a_c) ? oh : ((c >= r_c) ? ~oh : '0);
      exp_req_ready = (c == 0) ? oh : '0;
      exp_eng_start = in_q(starts, c);
      exp_busy      = (c >= 1);
      if (c >= 1) begin
        exp_gidx = 2'(lane);
        exp_id   = id;
        exp_ridx = 8'(count_lt(fails, c));
      end
      exp_rsp_valid   = (c >= r_c) ? oh : '0;
      exp_status      = (c >= r_c) ? 2'(st) : 2'd0;
      exp_rsp_retries = (c >= r_c) ? 8'(k) : 8'd0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_max_retries = '0; cfg_backoff = '0; cfg_timeout = '0;
    req_valid = '0; req_step_id = '0; eng_done = 1'b0; eng_pass = 1'b0; rsp_ready = '0;
    clear_exp();
    model_ptr = N - 1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Three lanes contending: grants rotate 0,1,3,0
    set_script(0, 1);
    for (int j = 0; j < 4; j++) begin
      do_job(4'b1011, 32'h100 + 32'(j), 1, 0, 0, 0, 0);
      lanes_seen[j] = obs_lane;
    end
    chk("rr_order0", 64'(lanes_seen[0]), 64'd0);
    chk("rr_order1", 64'(lanes_seen[1]), 64'd1);
    chk("rr_order2", 64'(lanes_seen[2]), 64'd3);
    chk("rr_order3", 64'(lanes_seen[3]), 64'd0);
    idle(1);

    // Single lane, first attempt passes
    set_script(0, 3);
    do_job(4'b0100, 32'hA5, 3, 2, 0, 0, 0);
    chk("t1_lane",    64'(obs_lane),    64'd2);
    chk("t1_status",  64'(obs_status),  64'd1);
    chk("t1_retries", 64'(obs_retries), 64'd0);
    chk("t1_starts",  64'(obs_starts.size()), 64'd1);
    chk("t1_lat",     64'(obs_starts[0] - m_t0), 64'd1);
    chk("t1_rsp_lat", 64'(obs_rsp_cyc - obs_starts[0]), 64'd4);
    idle(2);

    // Always failing engine with backoff 4 ends in rollback
    set_script(1, 2);
    do_job(4'b0001, 32'hBEEF, 2, 4, 0, 1, 0);
    chk("t3_starts",  64'(obs_starts.size()), 64'd3);
    chk("t3_gap",     64'(obs_starts[1] - obs_starts[0]), 64'd8);
    chk("t3_status",  64'(obs_status),  64'd2);
    chk("t3_retries", 64'(obs_retries), 64'd2);

    // Silent engine times out after 10 WAIT cycles
    set_script(2, 0);
    do_job(4'b0010, 32'h7777, 3, 1, 10, 0, 0);
    chk("t4_status",  64'(obs_status), 64'd3);
    chk("t4_tmo_lat", 64'(obs_rsp_cyc - obs_starts[0]), 64'd11);
    chk("t4_starts",  64'(obs_starts.size()), 64'd1);
    // Result on the expiry cycle wins
    set_script(0, 10);
    do_job(4'b0010, 32'h7778, 3, 1, 10, 0, 0);
    chk("t4_edge_pass", 64'(obs_status), 64'd1);
    // Failure on the expiry cycle still retries; zero backoff re-issues next cycle
    set_script(0, 2);
    scr_kind[0] = 1; scr_delay[0] = 10;
    do_job(4'b0010, 32'h7779, 1, 0, 10, 0, 0);
    chk("t4_edge_fail_retries", 64'(obs_retries), 64'd1);
    chk("t4_bo0_gap", 64'(obs_starts[1] - obs_starts[0]), 64'd12);

    // Held response with another lane waiting; mid-job cfg changes ignored
    set_script(0, 3);
    scr_kind[0] = 1; scr_delay[0] = 2;
    do_job(4'b1001, 32'hCAFE, 1, 1, 0, 7, 0);
    chk("t5_lane",    64'(obs_lane),    64'd3);
    chk("t5_status",  64'(obs_status),  64'd1);
    chk("t5_retries", 64'(obs_retries), 64'd1);
    set_script(0, 1);
    do_job(4'b1001, 32'hD00D, 0, 0, 0, 0, 0);
    chk("t5_next_lane", 64'(obs_lane), 64'd0);

    // Reset pulled during BACKOFF, then lane 0 has priority again
    set_script(1, 2);
    do_job(4'b0010, 32'h5151, 2, 4, 0, 0, 5);
    chk("t6_no_rsp", 64'(obs_rsp_seen), 64'd0);
    rst_n = 1'b1;
    idle(2);
    set_script(0, 2);
    do_job(4'b1111, 32'h6262, 2, 4, 0, 0, 0);
    chk("t6_lane",   64'(obs_lane),   64'd0);
    chk("t6_status", 64'(obs_status), 64'd1);
    idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
